cube_root: RTL and testbench

- Multi-cycle integer cube-root unit; the inverse of the team's `cube` block.
- Takes an unsigned X_WIDTH-bit operand and returns floor(cbrt(x)) as an unsigned Y_WIDTH-bit result.
- Uses the same start/busy handshake as `cube`, so a `cube` → `cube_root` pair can be chained and round-trip checked.
- Restoring digit-by-digit algorithm; one result bit per iteration, using a sequential shift-add multiplier.

---
 rtl/cube_pkg.sv | 21 ++
 rtl/cube_root_if.sv | 23 ++
 rtl/mult_seq.sv | 59 +++++
 rtl/cube_root.sv | 149 ++++++++++++++
 tb/tb_cube_root.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cube_pkg.sv
// Shared definitions for the cube / cube_root pair: default widths, FSM state
// encoding and the busy-cycle count helper.
package cube_pkg;

    localparam int CUBE_Y_W = 8;
    localparam int CUBE_X_W = 24;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREP     = 3'd1,
        MUL_WAIT = 3'd2,
        UPDATE   = 3'd3,
        DONE     = 3'd4
    } cube_state_e;

    // One result bit costs PREP + multiply + UPDATE cycles.
    function automatic int cube_iters(input int y_width);
        return y_width * (y_width + 2);
    endfunction

endpackage

// File: rtl/cube_root_if.sv
// Start/busy handshake bundle for cube_root.
// With CUBE_ROOT_REM_EN defined it also carries the remainder and exact flag.
interface cube_root_if #(
    parameter int Y_WIDTH = 8,
    parameter int X_WIDTH = 24
);
    logic               start_i;
    logic [X_WIDTH-1:0] x_bi;
    logic               busy_o;
    logic [Y_WIDTH-1:0] y_bo;
`ifdef CUBE_ROOT_REM_EN
    logic [X_WIDTH-1:0] rem_bo;
    logic               exact_o;

    modport master (output start_i, output x_bi,
                    input busy_o, input y_bo, input rem_bo, input exact_o);
    modport slave  (input start_i, input x_bi,
                    output busy_o, output y_bo, output rem_bo, output exact_o);
`else
    modport master (output start_i, output x_bi, input busy_o, input y_bo);
    modport slave  (input start_i, input x_bi, output busy_o, output y_bo);
`endif
endinterface

// File: rtl/mult_seq.sv
// Unsigned shift-add multiplier, A_W x (A_W+1) bits. The first partial product
// is taken on the start edge, so the product is valid A_W cycles after start.
module mult_seq #(
    parameter int A_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [A_W-1:0] a_i,
    input  logic [A_W:0]   b_i,
    output logic           busy_o,
    output logic [2*A_W:0] p_o
);
    localparam int PW = 2 * A_W + 1;
    localparam int CW = $clog2(A_W + 1);

    logic [A_W-1:0] a_q, a_d;
    logic [PW-1:0]  b_q, b_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i && (cnt_q == '0)) begin
            a_d   = a_i >> 1;
            b_d   = PW'(b_i) << 1;
            acc_d = a_i[0] ? PW'(b_i) : '0;
            cnt_d = CW'(A_W - 1);
        end else if (cnt_q != '0) begin
            if (a_q[0]) begin
                acc_d = acc_q + b_q;
            end
            a_d   = a_q >> 1;
            b_d   = b_q << 1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign p_o    = acc_q;

endmodule

// File: rtl/cube_root.sv
// Multi-cycle floor(cbrt(x)) using a restoring digit-by-digit recurrence.
// Define CUBE_ROOT_REM_EN to add rem_bo (x - y^3) and exact_o outputs.
module cube_root
    import cube_pkg::*;
#(
    parameter int Y_WIDTH = CUBE_Y_W,
    parameter int X_WIDTH = CUBE_X_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    cube_root_if.slave  bus
);
    localparam int SW = $clog2(X_WIDTH);
    localparam int BW = X_WIDTH + 16;
    localparam int PW = 2 * Y_WIDTH + 1;

    if (X_WIDTH != 3 * Y_WIDTH) begin : g_width_chk
        $error("cube_root: X_WIDTH must equal 3*Y_WIDTH");
    end

    cube_state_e        state_q, state_d;
    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic [SW-1:0]      s_q, s_d;
    logic [Y_WIDTH-1:0] y_out_q, y_out_d;
`ifdef CUBE_ROOT_REM_EN
    logic [X_WIDTH-1:0] rem_q, rem_d;
    logic               exact_q, exact_d;
`endif

    logic [Y_WIDTH-1:0] mul_a;
    logic [Y_WIDTH:0]   mul_b;
    logic [PW-1:0]      mul_p;
    logic               mul_busy;
    logic               mul_start;
    logic [BW-1:0]      trial;
    logic               fits;

    // Operands are the doubled partial root, i.e. the value y_q takes this edge.
    assign mul_a     = {y_q[Y_WIDTH-2:0], 1'b0};
    assign mul_b     = {1'b0, mul_a} + (Y_WIDTH + 1)'(1);
    assign mul_start = (state_q == PREP);

    mult_seq #(.A_W(Y_WIDTH)) u_mult (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_i     (mul_a),
        .b_i     (mul_b),
        .busy_o  (mul_busy),
        .p_o     (mul_p)
    );

    // (y+1)^3 - y^3 = 3y(y+1) + 1, aligned to the current digit position.
    assign trial = ((BW'(mul_p) * BW'(3)) + BW'(1)) << s_q;
    assign fits  = (BW'(x_q) >= trial);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start_i) state_d = PREP;
            PREP:     state_d = MUL_WAIT;
            MUL_WAIT: if (!mul_busy) state_d = UPDATE;
            UPDATE:   state_d = (s_q == '0) ? DONE : PREP;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (state_q == PREP) || (state_q == MUL_WAIT) || (state_q == UPDATE);
        bus.y_bo   = y_out_q;
`ifdef CUBE_ROOT_REM_EN
        bus.rem_bo  = rem_q;
        bus.exact_o = exact_q;
`endif
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        y_out_d = y_out_q;
`ifdef CUBE_ROOT_REM_EN
        rem_d   = rem_q;
        exact_d = exact_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    x_d = bus.x_bi;
                    y_d = '0;
                    s_d = SW'(3 * (Y_WIDTH - 1));
                end
            end
            PREP: begin
                y_d = mul_a;
            end
            UPDATE: begin
                if (fits) begin
                    x_d = x_q - trial[X_WIDTH-1:0];
                    y_d = y_q + Y_WIDTH'(1);
                end
                // Result registers only move on the final digit, never mid-run.
                if (s_q == '0) begin
                    y_out_d = y_d;
`ifdef CUBE_ROOT_REM_EN
                    rem_d   = x_d;
                    exact_d = (x_d == '0);
`endif
                end else begin
                    s_d = s_q - SW'(3);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            y_out_q <= '0;
`ifdef CUBE_ROOT_REM_EN
            rem_q   <= '0;
            exact_q <= 1'b0;
`endif
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            y_out_q <= y_out_d;
`ifdef CUBE_ROOT_REM_EN
            rem_q   <= rem_d;
            exact_q <= exact_d;
`endif
        end
    end

endmodule

// File: tb/tb_cube_root.sv
// Directed-vector bench for cube_root: table of operands with hand-computed
// roots, a round-trip sweep over k^3, and handshake/reset corner sequences.
module tb_cube_root;

    localparam int YW = 8;
    localparam int XW = 24;
    localparam int BUSY_CYCLES = 80;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cube_root_if #(.Y_WIDTH(YW), .X_WIDTH(XW)) bus ();

    cube_root #(.Y_WIDTH(YW), .X_WIDTH(XW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] rem;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One full transaction. inject_cyc>0 pulses start_i with x=1000 at that busy cycle.
    task automatic do_run(input logic [XW-1:0] x, input logic [YW-1:0] exp_y,
                          input logic [XW-1:0] exp_rem, input int inject_cyc);
        int cyc;
        int extra;
        logic [YW-1:0] prev;
        bit changed;
        @(negedge clk);
        bus.x_bi    = x;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.x_bi    = '1;
        prev    = bus.y_bo;
        cyc     = 0;
        changed = 1'b0;
        while (bus.busy_o === 1'b1 && cyc < 200) begin
            cyc++;
            if (bus.y_bo !== prev) changed = 1'b1;
            if (inject_cyc > 0 && cyc == inject_cyc) begin
                bus.start_i = 1'b1;
                bus.x_bi    = 24'd1000;
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        check("busy_cycles", 64'(cyc), 64'(BUSY_CYCLES));
        check("y_bo", 64'(bus.y_bo), 64'(exp_y));
        check("y_bo_held", 64'(changed), 64'd0);
`ifdef CUBE_ROOT_REM_EN
        check("rem_bo", 64'(bus.rem_bo), 64'(exp_rem));
        check("exact_o", 64'(bus.exact_o), 64'(exp_rem == '0));
`endif
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy_o !== 1'b0) extra++;
        end
        check("no_second_run", 64'(extra), 64'd0);
        $display("run x=%0d y=%0d exp_y=%0d exp_rem=%0d busy_cycles=%0d", x, bus.y_bo, exp_y, exp_rem, cyc);
    endtask

    initial begin
        int k;
        int n;
        vecs[0]  = '{24'd0,        8'd0,   24'd0};
        vecs[1]  = '{24'd1,        8'd1,   24'd0};
        vecs[2]  = '{24'd7,        8'd1,   24'd6};
        vecs[3]  = '{24'd8,        8'd2,   24'd0};
        vecs[4]  = '{24'd26,       8'd2,   24'd18};
        vecs[5]  = '{24'd27,       8'd3,   24'd0};
        vecs[6]  = '{24'd1728,     8'd12,  24'd0};
        vecs[7]  = '{24'd1727,     8'd11,  24'd396};
        vecs[8]  = '{24'd4096,     8'd16,  24'd0};
        vecs[9]  = '{24'd999999,   8'd99,  24'd29700};
        vecs[10] = '{24'd1000000,  8'd100, 24'd0};
        vecs[11] = '{24'd16777215, 8'd255, 24'd195840};
        vecs[12] = '{24'd16581375, 8'd255, 24'd0};

        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.x_bi    = '0;
        #12;
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_y", 64'(bus.y_bo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_run(vecs[i].x, vecs[i].y, vecs[i].rem, 0);
        end

        for (k = 1; k <= 121; k += 12) begin
            do_run(XW'(k * k * k), YW'(k), '0, 0);
        end

        // Start pulse and operand change while busy must be ignored.
        do_run(24'd27, 8'd3, 24'd0, 30);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bus.x_bi    = 24'd125;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (39) @(negedge clk);
        check("busy_before_rst", 64'(bus.busy_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(bus.busy_o), 64'd0);
        check("async_rst_y", 64'(bus.y_bo), 64'd0);
        $display("async reset at busy cycle 40 busy=%0d y=%0d", bus.busy_o, bus.y_bo);
        @(negedge clk);
        rst = 1'b0;
        do_run(24'd343, 8'd7, 24'd0, 0);

        // start_i held high: a new run must begin shortly after busy_o falls.
        @(negedge clk);
        bus.x_bi    = 24'd8;
        bus.start_i = 1'b1;
        n = 0;
        while (bus.busy_o !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        n = 0;
        while (bus.busy_o === 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("held_first_len", 64'(n), 64'(BUSY_CYCLES));
        check("held_first_y", 64'(bus.y_bo), 64'd2);
        n = 0;
        while (bus.busy_o !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        check("held_restart", 64'(bus.busy_o), 64'd1);
        bus.start_i = 1'b0;
        bus.x_bi    = '0;
        n = 0;
        while (bus.busy_o === 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("held_second_y", 64'(bus.y_bo), 64'd2);
        $display("held start restart_gap=%0d second_y=%0d", n, bus.y_bo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
